// File: rtl/echo_scheduler.sv
// Echo scheduler: mixes three note voices with an attenuated, delayed copy
// of its own past output. A CLEAR sweep zeroes the delay buffer after reset.
// Each accepted sample then goes through READ -> SUM -> WRITE, so the block
// takes one sample per four cycles at most.
module echo_scheduler #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_sample,
  input  logic [15:0]       song_one,
  input  logic [15:0]       song_two,
  input  logic [15:0]       song_three,
  input  logic              echo_en,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic [1:0]        atten,
  output logic              ready,
  output logic [17:0]       out,
  output logic              out_valid,
  output logic              overrun
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {CLEAR, IDLE, READ, SUM, WRITE} state_t;

  // Controls captured on acceptance, so later input changes do not touch the sample in flight
  typedef struct packed {
    logic [15:0]       s1;
    logic [15:0]       s2;
    logic [15:0]       s3;
    logic              echo_en;
    logic [ADDR_W-1:0] delay_len;
    logic [1:0]        atten;
  } cap_t;

  state_t            state, nxt;
  cap_t              cap;
  logic [ADDR_W-1:0] clr_addr, wr_ptr, rd_addr;
  logic [17:0]       mem [DEPTH];
  logic [17:0]       rd_data, echo_term, sat, sat_q;
  logic [18:0]       total;

  // Next state and ready
  always_comb begin
    nxt   = state;
    ready = 1'b0;
    case (state)
      CLEAR: if (clr_addr == {ADDR_W{1'b1}}) nxt = IDLE;
      IDLE: begin
        ready = 1'b1;
        if (new_sample) nxt = READ;
      end
      READ:    nxt = SUM;
      SUM:     nxt = WRITE;
      WRITE:   nxt = IDLE;
      default: nxt = CLEAR;
    endcase
  end

  // Mix path: echo read address, shifted echo, 19-bit sum, then saturate to 18 bits.
  // A zero delay forces no echo, so the slot about to be written is never echoed.
  always_comb begin
    rd_addr   = wr_ptr - cap.delay_len;
    echo_term = (cap.echo_en && cap.delay_len != '0) ?
                (rd_data >> ({1'b0, cap.atten} + 3'd1)) : 18'd0;
    total     = 19'(cap.s1) + 19'(cap.s2) + 19'(cap.s3) + 19'(echo_term);
    sat       = (total > 19'd262143) ? 18'h3FFFF : total[17:0];
  end

  // Control and datapath registers; reset aborts any sample in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= CLEAR;
      clr_addr  <= '0;
      wr_ptr    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      cap       <= '0;
      sat_q     <= '0;
    end else begin
      state     <= nxt;
      out_valid <= (state == WRITE);
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
      if (state == IDLE && new_sample)
        cap <= '{s1: song_one, s2: song_two, s3: song_three,
                 echo_en: echo_en, delay_len: delay_len, atten: atten};
      if (state == SUM) sat_q <= sat;
      if (state == WRITE) begin
        out    <= sat_q;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (new_sample && (state == READ || state == SUM || state == WRITE))
        overrun <= 1'b1;
    end
  end

  // Delay buffer: one write port (clear sweep or new sample) and a registered read.
  // Its contents are not reset; the CLEAR sweep zeroes them instead.
  always_ff @(posedge clk) begin
    if (state == CLEAR)      mem[clr_addr] <= '0;
    else if (state == WRITE) mem[wr_ptr]   <= sat_q;
    if (state == READ)       rd_data       <= mem[rd_addr];
  end

endmodule
